// File: rtl/fb_pkg.sv
// Shared constants and state type for the framebuffer arbiter slice.
package fb_pkg;

    localparam int unsigned ADDR_W   = 18;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned FB_DEPTH = 76800;

    typedef enum logic {
        IDLE,
        CLEAR
    } fb_state_e;

endpackage

// File: rtl/fb_arbiter_if.sv
// Requester-side and RAM-side signals of the framebuffer arbiter.
interface fb_arbiter_if
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_W = fb_pkg::ADDR_W,
    parameter int unsigned DATA_W = fb_pkg::DATA_W
);

    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_data;

    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    logic              clr_start;
    logic [DATA_W-1:0] clr_color;
    logic              clr_busy;
    logic              clr_done;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  disp_req, disp_addr, wr_valid, wr_addr, wr_data,
               clr_start, clr_color, mem_rdata,
        output disp_valid, disp_data, wr_ready, clr_busy, clr_done,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output disp_req, disp_addr, wr_valid, wr_addr, wr_data,
               clr_start, clr_color, mem_rdata,
        input  disp_valid, disp_data, wr_ready, clr_busy, clr_done,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/fb_clear_seq.sv
// Full-frame clear sequencer: walks every valid address, yielding to display reads.
module fb_clear_seq
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_W   = fb_pkg::ADDR_W,
    parameter int unsigned DATA_W   = fb_pkg::DATA_W,
    parameter int unsigned FB_DEPTH = fb_pkg::FB_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    input  logic              disp_req,
    output logic              clr_busy,
    output logic              clr_issue,
    output logic [ADDR_W-1:0] clr_addr,
    output logic [DATA_W-1:0] clr_wdata,
    output logic              clr_done
);

    // Compare against the last address so FB_DEPTH == 2**ADDR_W cannot truncate to zero.
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_DEPTH - 1);

    fb_state_e         state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] color;
    logic              done_q;
    logic              start;
    logic              last;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        clr_issue = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    start     = 1'b1;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                if (!disp_req) begin
                    clr_issue = 1'b1;
                    if (cnt == LAST) begin
                        last      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            color  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= last;
            if (start) begin
                cnt   <= '0;
                color <= clr_color;
            end else if (clr_issue) begin
                cnt <= last ? '0 : cnt + 1'b1;
            end
        end
    end

    assign clr_busy  = (state == CLEAR);
    assign clr_addr  = cnt;
    assign clr_wdata = color;
    assign clr_done  = done_q;

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: display reads > clear writes > draw-engine writes.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_W   = fb_pkg::ADDR_W,
    parameter int unsigned DATA_W   = fb_pkg::DATA_W,
    parameter int unsigned FB_DEPTH = fb_pkg::FB_DEPTH
) (
    input  logic clk,
    input  logic reset,
    fb_arbiter_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_DEPTH - 1);

    logic              clr_busy;
    logic              clr_issue;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_wdata;
    logic              clr_done;

    logic              disp_inr;
    logic              wr_inr;
    logic              wr_ready;
    logic              wr_fire;

    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic              p1_valid, p1_inr;
    logic              p2_valid, p2_inr;

    fb_clear_seq #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .FB_DEPTH (FB_DEPTH)
    ) u_clear_seq (
        .clk       (clk),
        .reset     (reset),
        .clr_start (bus.clr_start),
        .clr_color (bus.clr_color),
        .disp_req  (bus.disp_req),
        .clr_busy  (clr_busy),
        .clr_issue (clr_issue),
        .clr_addr  (clr_addr),
        .clr_wdata (clr_wdata),
        .clr_done  (clr_done)
    );

    assign disp_inr = (bus.disp_addr <= LAST);
    assign wr_inr   = (bus.wr_addr <= LAST);
    // Gated by reset so every output reads zero while reset is held.
    assign wr_ready = !reset && !bus.disp_req && !clr_busy;
    assign wr_fire  = bus.wr_valid && wr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else if (bus.disp_req) begin
            mem_en_q   <= disp_inr;
            mem_we_q   <= 1'b0;
            mem_addr_q <= bus.disp_addr;
        end else if (clr_issue) begin
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= clr_addr;
            mem_wdata_q <= clr_wdata;
        end else if (wr_fire) begin
            mem_en_q    <= wr_inr;
            mem_we_q    <= wr_inr;
            mem_addr_q  <= bus.wr_addr;
            mem_wdata_q <= bus.wr_data;
        end else begin
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_valid <= 1'b0;
            p1_inr   <= 1'b0;
            p2_valid <= 1'b0;
            p2_inr   <= 1'b0;
        end else begin
            p1_valid <= bus.disp_req;
            p1_inr   <= bus.disp_req && disp_inr;
            p2_valid <= p1_valid;
            p2_inr   <= p1_inr;
        end
    end

    // RAM data arrives in the same cycle the response is flagged, so it is muxed, not registered.
    assign bus.disp_valid = p2_valid;
    assign bus.disp_data  = p2_inr ? bus.mem_rdata : '0;
    assign bus.wr_ready   = wr_ready;
    assign bus.clr_busy   = clr_busy;
    assign bus.clr_done   = clr_done;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule
